// File: rtl/mul_pkg.sv
// Shared definitions for the two-port multiply arbiter: op codes, FSM states, data width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MUL    = 2'd0;  // low word, sign-agnostic
  localparam logic [1:0] MULH   = 2'd1;  // high word, signed x signed
  localparam logic [1:0] MULHSU = 2'd2;  // high word, signed x unsigned
  localparam logic [1:0] MULHU  = 2'd3;  // high word, unsigned x unsigned

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/boothmul.sv
// Iterative radix-2 Booth multiplier for signed OPW-bit operands; returns the low RW product bits.
// Latency: OPW cycles of shift/add after the accept cycle, then a one-cycle o_out_valid pulse.
// Backpressure: o_in_ready is low while an operation iterates; the result pulse cannot be stalled.
module boothmul #(
  parameter int OPW = 33,
  parameter int RW  = 64
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic           o_out_valid,
  output logic [RW-1:0]  o_result
);

  // Accumulator carries one guard bit so subtracting the most negative multiplicand cannot overflow.
  logic           r_busy;
  logic [5:0]     r_cnt;
  logic [OPW:0]   r_acc;
  logic [OPW-1:0] r_q;
  logic           r_q1;
  logic [OPW-1:0] r_m;
  logic           r_out_valid;

  logic [OPW:0]   w_m_ext;
  logic [OPW:0]   w_sum;
  logic           w_unused;

  assign w_m_ext     = {r_m[OPW-1], r_m};
  assign o_in_ready  = ~r_busy;
  assign o_out_valid = r_out_valid;
  assign o_result    = {r_acc[RW-OPW-1:0], r_q};
  assign w_unused    = &{1'b0, r_acc[OPW:RW-OPW]};

  // Booth recoding of the current multiplier bit pair selects add, subtract or pass.
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
  end

  // Load operands on accept, then one arithmetic right shift of {acc, q, q1} per cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy      <= 1'b0;
      r_cnt       <= 6'd0;
      r_acc       <= '0;
      r_q         <= '0;
      r_q1        <= 1'b0;
      r_m         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (!r_busy && i_in_valid) begin
        r_busy <= 1'b1;
        r_cnt  <= 6'(OPW);
        r_acc  <= '0;
        r_q    <= i_a;
        r_q1   <= 1'b0;
        r_m    <= i_b;
      end else if (r_busy) begin
        r_acc <= {w_sum[OPW], w_sum[OPW:1]};
        r_q   <= {w_sum[0], r_q[OPW-1:1]};
        r_q1  <= r_q[0];
        r_cnt <= r_cnt - 6'd1;
        if (r_cnt == 6'd1) begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Two-port round-robin front end sharing one Booth multiplier; one operation in flight at a time.
// Latency: grant to resp_valid_o is multiplier latency + 2 cycles (ISSUE plus result capture).
// Backpressure: req_ready_o only in IDLE; the response is held stable until the owner's resp_ready_i.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int XLEN  = mul_pkg::XLEN,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][1:0]       req_op_i,
  input  logic [1:0][XLEN-1:0]  req_src1_i,
  input  logic [1:0][XLEN-1:0]  req_src2_i,
  input  logic [1:0][TAG_W-1:0] req_tag_i,
  output logic [1:0]            resp_valid_o,
  input  logic [1:0]            resp_ready_i,
  output logic [XLEN-1:0]       resp_data_o,
  output logic [TAG_W-1:0]      resp_tag_o,
  output logic                  busy_o
);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_src1;
  logic [XLEN-1:0]   r_src2;
  logic [TAG_W-1:0]  r_tag;
  logic [XLEN-1:0]   r_resp_data;

  logic              w_any;
  logic              w_grant;
  logic [XLEN:0]     w_mul_a;
  logic [XLEN:0]     w_mul_b;
  logic              w_mul_in_valid;
  logic              w_mul_in_ready;
  logic              w_mul_out_valid;
  logic [2*XLEN-1:0] w_mul_result;

  assign w_any          = |req_valid_i;
  assign w_mul_in_valid = (r_state == ISSUE);
  assign busy_o         = (r_state != IDLE);
  assign resp_valid_o   = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data_o    = r_resp_data;
  assign resp_tag_o     = r_tag;

  // A lone requester wins outright; on contention the port that did not win last time goes.
  always_comb begin
    if (req_valid_i == 2'b11) w_grant = ~r_last_grant;
    else                      w_grant = req_valid_i[1];
  end

  // Combinational accept for the granted port only, and never while reset is asserted.
  always_comb begin
    req_ready_o = 2'b00;
    if (!reset && r_state == IDLE && w_any) req_ready_o[w_grant] = 1'b1;
  end

  // Widen to the multiplier's 33-bit signed domain; zero extension makes an operand unsigned.
  always_comb begin
    w_mul_a = (r_op == MULHU) ? {1'b0, r_src1} : {r_src1[XLEN-1], r_src1};
    w_mul_b = (r_op == MUL || r_op == MULH) ? {r_src2[XLEN-1], r_src2} : {1'b0, r_src2};
  end

  // Control FSM: latch on grant, issue, capture the selected result half, hold until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= MUL;
      r_src1       <= '0;
      r_src2       <= '0;
      r_tag        <= '0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_op         <= req_op_i[w_grant];
            r_src1       <= req_src1_i[w_grant];
            r_src2       <= req_src2_i[w_grant];
            r_tag        <= req_tag_i[w_grant];
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_mul_in_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (w_mul_out_valid) begin
            r_resp_data <= (r_op == MUL) ? w_mul_result[XLEN-1:0] : w_mul_result[2*XLEN-1:XLEN];
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i[r_owner]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  boothmul #(
    .OPW(XLEN + 1),
    .RW (2 * XLEN)
  ) u_boothmul (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_in_valid (w_mul_in_valid),
    .o_in_ready (w_mul_in_ready),
    .i_a        (w_mul_a),
    .i_b        (w_mul_b),
    .o_out_valid(w_mul_out_valid),
    .o_result   (w_mul_result)
  );

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand width; the only supported value is 32.
REQ-002 Parameter TAG_W, default 4, width of the requester tag returned with each result.
REQ-003 clk  input  1  single clock; all state updates on the posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid_i[1:0]  input  2  per-port request valid, i = 0,1.
REQ-006 req_ready_o[1:0]  output  2  per-port request accept.
REQ-007 req_op_i  input  2 per port  operation: 0=MUL (low word), 1=MULH (signed x signed, high), 2=MULHSU (signed x unsigned, high), 3=MULHU (unsigned x unsigned, high).
REQ-008 req_src1_i, req_src2_i  input  XLEN per port  operands.
REQ-009 req_tag_i  input  TAG_W per port  requester tag.
REQ-010 resp_valid_o[1:0]  output  2  per-port result valid.
REQ-011 resp_ready_i[1:0]  input  2  per-port result accept.
REQ-012 resp_data_o  output  XLEN  result word; shared by both ports, meaningful only with the matching resp_valid_o bit.
REQ-013 resp_tag_o  output  TAG_W  tag of the request being answered.
REQ-014 busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL own one boothmul instance with a 33-bit operand width and 64-bit result, driven only by this block.
REQ-016 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: when any req_valid_i is high, req_ready_o SHALL be high for the granted port only, in the same cycle (combinational grant).
REQ-018 On the grant handshake, the FSM SHALL latch the op, operands, tag and owner, then go to ISSUE.
REQ-019 Arbitration SHALL be round-robin on a 1-bit last_grant register.
- If only one port is valid, that port is granted.
- If both ports are valid, the port != last_grant is granted.
- last_grant updates on every grant.
REQ-020 Operand extension:
- src1 SHALL be sign-extended to 33 bits for MUL, MULH and MULHSU, and zero-extended for MULHU.
- src2 SHALL be sign-extended for MUL and MULH, and zero-extended for MULHSU and MULHU.
REQ-021 ISSUE: mul in_valid SHALL be high; when the multiplier's in_ready is also high, go to WAIT.
REQ-022 WAIT: on the multiplier's one-cycle out_valid pulse, the FSM SHALL capture resp_data (result[31:0] for MUL, result[63:32] otherwise), then go to RESP.
REQ-023 RESP: resp_valid_o[owner] SHALL be high and the other bit low; on resp_ready_i[owner], go to IDLE.
REQ-024 resp_data_o and resp_tag_o SHALL stay stable while resp_valid_o is high.
REQ-025 Only one operation SHALL be in flight; req_ready_o SHALL be 0 in ISSUE, WAIT and RESP.
REQ-026 The earliest new grant after a response handshake is the cycle after it, in IDLE; there is no back-to-back bypass.
REQ-027 Requests arriving while busy SHALL stay pending on their own valid signal and are not dropped.
REQ-028 Minimum latency from grant to resp_valid_o SHALL be multiplier latency + 2 cycles.
REQ-029 A resp_ready_i bit on the non-owner port SHALL be ignored.

Reset
REQ-030 On reset the FSM SHALL go to IDLE, last_grant to 1 (port 0 wins first), and the boothmul instance SHALL be reset by the same reset.
REQ-031 Reset mid-operation SHALL abandon the operation with no response.
REQ-032 Reset values of the outputs:
- req_ready_o = 0 during reset.
- resp_valid_o = 0.
- busy_o = 0.
- resp_data_o = 0.
- resp_tag_o = 0.

Structure
REQ-033 A shared package mul_pkg SHALL hold:
- the op encoding constants MUL, MULH, MULHSU, MULHU;
- the FSM state typedef;
- XLEN.
REQ-034 boothmul SHALL be the only sub-module; arbitration, extension and result select stay inline.

Verification
REQ-035 Port 0, MUL, 7 x 0xFFFFFFFD, tag 3 -> resp_valid_o[0], data 0xFFFFFFEB, tag 3.
REQ-036 Port 1, MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> data 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-037 Both ports valid continuously after reset, 4 ops -> grant order 0,1,0,1; each response goes to the correct port with the correct tag.
REQ-038 resp_ready_i[owner] held low 10 cycles -> resp_valid_o and data stable, req_ready_o = 0 throughout; resp_ready_i on the non-owner port has no effect.
REQ-039 Reset asserted in WAIT -> next cycle IDLE, busy_o = 0, no response ever; a new MUL 2 x 3 -> 6.
